alg4_bytes_to_bits_stream: RTL and testbench

Streaming ML-KEM BytesToBits converter (FIPS 203 Algorithm 4). It is the inverse of the combinational BitsToBytes packer.
- Accepts a byte stream over a valid/ready handshake.
- Emits each byte LSB-first as OUT_W-bit chunks over a second valid/ready handshake.
- Tags message boundaries every LEN bytes and flags s_last framing mismatches.
- Sits between byte-oriented buffers (seed/ciphertext RAM readers) and bit-consuming decode/sampling stages.

---
 rtl/alg4_bytes_to_bits_stream.sv | 63 ++++++
 tb/tb_alg4_bytes_to_bits_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alg4_bytes_to_bits_stream.sv
// alg4_bytes_to_bits_stream: streaming BytesToBits, bytes in over s_*, LSB-first OUT_W-bit chunks out over m_*, with m_last/bit_idx message tagging and len_err framing check; clk/rst sync active-high
module alg4_bytes_to_bits_stream #(
  parameter int LEN = 32,
  parameter int OUT_W = 1,
  parameter int IDX_W = $clog2(8 * LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_bits,
  output logic             m_last,
  output logic [IDX_W-1:0] bit_idx,
  output logic             len_err
);
  localparam int NC = 8 / OUT_W;
  localparam int CW = LEN > 1 ? $clog2(LEN) : 1;
  localparam int KW = NC > 1 ? $clog2(NC) : 1;
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t state, state_nxt;
  logic [7:0] sr;
  logic [KW-1:0] chunk_idx;
  logic [CW-1:0] byte_cnt, cnt_nxt, cnt_in;
  logic last_chunk, fire, load, cnt_end;
  always_comb begin
    m_valid = state == HOLD;
    last_chunk = chunk_idx == KW'(NC - 1);
    fire = m_valid && m_ready;
    s_ready = !rst && (state == EMPTY || (last_chunk && fire));
    load = s_valid && s_ready;
    cnt_end = byte_cnt == CW'(LEN - 1);
    cnt_nxt = cnt_end ? '0 : byte_cnt + 1'b1;
    cnt_in = state == EMPTY ? byte_cnt : cnt_nxt;
    state_nxt = load ? HOLD : (fire && last_chunk) ? EMPTY : state;
    m_bits = m_valid ? sr[OUT_W-1:0] : '0;
    m_last = m_valid && cnt_end && last_chunk;
    bit_idx = IDX_W'({byte_cnt, 3'b000}) + IDX_W'(32'(chunk_idx) * OUT_W);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      sr <= '0;
      chunk_idx <= '0;
      byte_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      state <= state_nxt;
      len_err <= load && (s_last != (cnt_in == CW'(LEN - 1)));
      if (fire && last_chunk) byte_cnt <= cnt_nxt;
      if (load) begin
        sr <= s_data;
        chunk_idx <= '0;
      end else if (fire) begin
        sr <= sr >> OUT_W;
        chunk_idx <= last_chunk ? '0 : chunk_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alg4_bytes_to_bits_stream.sv
// tb_alg4_bytes_to_bits_stream: directed and randomized checks of the BytesToBits stream over several LEN/OUT_W builds
module tb_alg4_bytes_to_bits_stream;
  localparam int LENS [7] = '{2, 2, 4, 32, 32, 32, 32};
  localparam int OWS [7] = '{1, 4, 8, 1, 2, 4, 8};
  logic clk, rst;
  logic sv [7], srd [7], sl [7], mv [7], mr [7], ml [7], le [7];
  logic [7:0] sd [7], mb [7], bi [7];
  int total = 0, bad = 0;

  for (genvar g = 0; g < 7; g++) begin : gen_dut
    localparam int L = LENS[g];
    localparam int W = OWS[g];
    logic [W-1:0] b;
    logic [$clog2(8*L)-1:0] x;
    alg4_bytes_to_bits_stream #(.LEN(L), .OUT_W(W)) dut (
      .clk(clk), .rst(rst), .s_valid(sv[g]), .s_ready(srd[g]), .s_data(sd[g]), .s_last(sl[g]),
      .m_valid(mv[g]), .m_ready(mr[g]), .m_bits(b), .m_last(ml[g]), .bit_idx(x), .len_err(le[g]));
    assign mb[g] = 8'(b);
    assign bi[g] = 8'(x);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int j = 0; j < 7; j++) begin
      sv[j] = 1'b1; sd[j] = 8'hFF; sl[j] = 1'b0; mr[j] = 1'b1;
    end
    tick;
    tick;
    for (int j = 0; j < 7; j++) begin
      total++;
      if (mv[j] !== 1'b0 || ml[j] !== 1'b0 || bi[j] !== 8'd0 || le[j] !== 1'b0 || mb[j] !== 8'd0 || srd[j] !== 1'b0) begin
        bad++;
        $display("FAIL reset inst%0d: mv=%b ml=%b bi=%0d le=%b mb=%h srd=%b, want all 0", j, mv[j], ml[j], bi[j], le[j], mb[j], srd[j]);
      end
    end
    rst = 1'b0;
    for (int j = 0; j < 7; j++) begin
      sv[j] = 1'b0; mr[j] = 1'b0;
    end
    #1;
    for (int j = 0; j < 7; j++) begin
      total++;
      if (srd[j] !== 1'b1) begin
        bad++;
        $display("FAIL reset_release_ready inst%0d: srd=%b want 1", j, srd[j]);
      end
    end
  endtask

  task automatic test_base;
    logic [15:0] w = 16'h0102;
    int k = 0, n = 0, acc = 0;
    for (int c = 0; c < 24; c++) begin
      tick;
      total++;
      if (le[0] !== 1'b0) begin bad++; $display("FAIL base_len_err cycle %0d: le=%b want 0", c, le[0]); end
      sv[0] = k < 2; sd[0] = k == 0 ? 8'h02 : 8'h01; sl[0] = k == 1; mr[0] = 1'b1;
      #1;
      if (mv[0]) begin
        total++;
        if (mb[0] !== {7'b0, w[n[3:0]]} || bi[0] !== 8'(n) || ml[0] !== (n == 15) || c != acc + 1 + n) begin
          bad++;
          $display("FAIL base_chunk%0d: bit=%b idx=%0d last=%b cycle=%0d, want bit=%b idx=%0d last=%b cycle=%0d",
                   n, mb[0][0], bi[0], ml[0], c, w[n[3:0]], n, n == 15, acc + 1 + n);
        end
        n++;
      end
      if (sv[0] && srd[0]) begin
        if (k == 0) acc = c;
        k++;
      end
    end
    sv[0] = 1'b0;
    total++;
    if (n != 16) begin bad++; $display("FAIL base_count: chunks=%0d want 16", n); end
  endtask

  task automatic test_stall;
    int mrt [9] = '{1, 0, 1, 0, 0, 1, 1, 1, 0};
    int emv [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    int emb [9] = '{0, 10, 10, 10, 10, 10, 5, 5, 0};
    int ebi [9] = '{0, 0, 0, 4, 4, 4, 8, 12, 0};
    int eml [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    int esr [9] = '{1, 0, 0, 0, 0, 1, 0, 1, 1};
    for (int t = 0; t < 9; t++) begin
      tick;
      total++;
      if (le[1] !== 1'b0) begin bad++; $display("FAIL stall_len_err t%0d: le=%b want 0", t, le[1]); end
      sv[1] = t <= 5; sd[1] = t < 5 ? 8'hAA : 8'h55; sl[1] = t == 5; mr[1] = mrt[t] != 0;
      #1;
      total++;
      if (mv[1] !== (emv[t] != 0) || mb[1] !== 8'(emb[t]) || ml[1] !== (eml[t] != 0) || srd[1] !== (esr[t] != 0) ||
          (mv[1] && bi[1] !== 8'(ebi[t]))) begin
        bad++;
        $display("FAIL stall t%0d: mv=%b mb=%h ml=%b srd=%b bi=%0d, want mv=%0d mb=%h ml=%0d srd=%0d bi=%0d",
                 t, mv[1], mb[1], ml[1], srd[1], bi[1], emv[t], emb[t], eml[t], esr[t], ebi[t]);
      end
    end
    sv[1] = 1'b0; mr[1] = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] by [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int t = 0; t < 6; t++) begin
      tick;
      total++;
      if (le[2] !== 1'b0) begin bad++; $display("FAIL b2b_len_err t%0d: le=%b want 0", t, le[2]); end
      sv[2] = t < 4; sd[2] = by[t < 4 ? t : 0]; sl[2] = t == 3; mr[2] = 1'b1;
      #1;
      if (t < 5) begin
        total++;
        if (srd[2] !== 1'b1) begin bad++; $display("FAIL b2b_ready t%0d: srd=%b want 1", t, srd[2]); end
      end
      if (t >= 1 && t <= 4) begin
        total++;
        if (mv[2] !== 1'b1 || mb[2] !== by[t-1] || bi[2] !== 8'(8 * (t - 1)) || ml[2] !== (t == 4)) begin
          bad++;
          $display("FAIL b2b t%0d: mv=%b mb=%h bi=%0d ml=%b, want mv=1 mb=%h bi=%0d ml=%b", t, mv[2], mb[2], bi[2], ml[2], by[t-1], 8 * (t - 1), t == 4);
        end
      end
      if (t == 5) begin
        total++;
        if (mv[2] !== 1'b0) begin bad++; $display("FAIL b2b_idle: mv=%b want 0", mv[2]); end
      end
    end
    sv[2] = 1'b0; mr[2] = 1'b0;
  endtask

  task automatic test_framing;
    logic [7:0] by [4] = '{8'hC3, 8'h5A, 8'h0F, 8'hF0};
    logic sls [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic pend = 1'b0;
    logic [7:0] cur;
    int k = 0, n = 0, nle = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      total++;
      if (le[0] !== pend) begin bad++; $display("FAIL framing_len_err cycle %0d: le=%b want %b", c, le[0], pend); end
      if (le[0] === 1'b1) nle++;
      pend = 1'b0;
      sv[0] = k < 4; sd[0] = by[k % 4]; sl[0] = sls[k % 4]; mr[0] = 1'b1;
      #1;
      if (mv[0]) begin
        cur = n < 32 ? by[n / 8] : 8'hxx;
        total++;
        if (mb[0] !== {7'b0, cur[n % 8]} || ml[0] !== (n % 16 == 15)) begin
          bad++;
          $display("FAIL framing_chunk%0d: bit=%b last=%b, want bit=%b last=%b", n, mb[0][0], ml[0], cur[n % 8], n % 16 == 15);
        end
        n++;
      end
      if (sv[0] && srd[0]) begin
        pend = sl[0] != (k % 2 == 1);
        k++;
      end
    end
    sv[0] = 1'b0;
    total++;
    if (n != 32 || nle != 2) begin bad++; $display("FAIL framing_totals: chunks=%0d pulses=%0d want 32 and 2", n, nle); end
  endtask

  task automatic test_reset_mid;
    int k = 0, n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick;
      sv[0] = k < 2; sd[0] = k == 0 ? 8'h00 : 8'hFF; sl[0] = k == 1; mr[0] = 1'b1;
      #1;
      if (k == 2 && mv[0] && mr[0]) n++;
      if (sv[0] && srd[0]) k++;
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL rstmid_prep: chunks=%0d want 3", n); end
    tick;
    rst = 1'b1; sv[0] = 1'b0;
    tick;
    total++;
    if (mv[0] !== 1'b0 || bi[0] !== 8'd0 || ml[0] !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_after: mv=%b bi=%0d ml=%b want 0 0 0", mv[0], bi[0], ml[0]);
    end
    rst = 1'b0;
    k = 0; n = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      total++;
      if (le[0] !== 1'b0) begin bad++; $display("FAIL rstmid_len_err cycle %0d: le=%b want 0", c, le[0]); end
      sv[0] = k < 1; sd[0] = 8'h80; sl[0] = 1'b0; mr[0] = 1'b1;
      #1;
      if (mv[0]) begin
        total++;
        if (mb[0] !== {7'b0, n == 7} || bi[0] !== 8'(n) || ml[0] !== 1'b0) begin
          bad++;
          $display("FAIL rstmid_chunk%0d: bit=%b bi=%0d ml=%b, want bit=%b bi=%0d ml=0", n, mb[0][0], bi[0], ml[0], n == 7, n);
        end
        n++;
      end
      if (sv[0] && srd[0]) k++;
    end
    sv[0] = 1'b0;
    total++;
    if (n != 8) begin bad++; $display("FAIL rstmid_count: chunks=%0d want 8", n); end
  endtask

  task automatic test_random;
    logic [7:0] src [4][64];
    logic [7:0] rcv [4][64];
    int sent [4], pos [4];
    logic pend [4];
    logic [7:0] e;
    int j, w, p;
    bit busy;
    for (int q = 0; q < 4; q++) begin
      sent[q] = 0; pos[q] = 0; pend[q] = 1'b0;
      for (int i = 0; i < 64; i++) begin src[q][i] = 8'($urandom); rcv[q][i] = 8'h00; end
    end
    busy = 1'b1;
    for (int c = 0; c < 10000 && busy; c++) begin
      tick;
      for (int q = 0; q < 4; q++) begin
        j = q + 3;
        total++;
        if (le[j] !== pend[q]) begin bad++; $display("FAIL rand_len_err inst%0d cycle %0d: le=%b want %b", j, c, le[j], pend[q]); end
        pend[q] = 1'b0;
        sv[j] = sent[q] < 64 && $urandom_range(3) != 0;
        sd[j] = sent[q] < 64 ? src[q][sent[q]] : 8'h00;
        sl[j] = (sent[q] % 32 == 31) ^ ($urandom_range(7) == 0);
        mr[j] = $urandom_range(2) != 0;
      end
      #1;
      busy = 1'b0;
      for (int q = 0; q < 4; q++) begin
        j = q + 3; w = OWS[j]; p = pos[q];
        if (mv[j] && mr[j]) begin
          e = p < 512 ? (src[q][p / 8] >> (p % 8)) & 8'((1 << w) - 1) : 8'hxx;
          total++;
          if (mb[j] !== e || bi[j] !== 8'(p % 256) || ml[j] !== ((p + w) % 256 == 0)) begin
            bad++;
            $display("FAIL rand_chunk inst%0d pos %0d: mb=%h bi=%0d ml=%b, want mb=%h bi=%0d ml=%b", j, p, mb[j], bi[j], ml[j], e, p % 256, (p + w) % 256 == 0);
          end
          if (p < 512) rcv[q][p / 8] = rcv[q][p / 8] | 8'(mb[j] << (p % 8));
          pos[q] = p + w;
        end
        if (sv[j] && srd[j]) begin
          pend[q] = sl[j] != (sent[q] % 32 == 31);
          sent[q]++;
        end
        if (pos[q] < 512) busy = 1'b1;
      end
    end
    tick;
    for (int q = 0; q < 4; q++) begin
      j = q + 3;
      sv[j] = 1'b0; mr[j] = 1'b0;
      total++;
      if (le[j] !== pend[q] || pos[q] != 512) begin
        bad++;
        $display("FAIL rand_end inst%0d: le=%b bits=%0d, want le=%b bits=512", j, le[j], pos[q], pend[q]);
      end
      for (int i = 0; i < 64; i++) begin
        total++;
        if (rcv[q][i] !== src[q][i]) begin
          bad++;
          $display("FAIL rand_reassemble inst%0d byte %0d: got %h want %h", j, i, rcv[q][i], src[q][i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_base;
    test_stall;
    test_back_to_back;
    test_framing;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
